opb_register_ppc2simulink: RTL and testbench
============================================

# opb_register_ppc2simulink

Single-word OPB slave register that the PPC writes and the Simulink user logic reads; it is the write-direction counterpart of the simulink2ppc status registers on the same OPB bus. It decodes one 32-bit word inside its address window, merges written bytes under OPB_BE, returns a fixed-latency Sl_xferAck, and presents the stored word plus a one-cycle update strobe to the user fabric. It is placed per control register (e.g. GPU mcnt offset, FFT shift) in the XPS base system.

## Interface
- C_BASEADDR, 32'h00000000, window start; the register is the word at C_BASEADDR
- C_HIGHADDR, 32'h000000FF, window end; any address in [C_BASEADDR, C_HIGHADDR] selects the block
- C_OPB_AWIDTH, 32, address width
- C_OPB_DWIDTH, 32, data width (only 32 supported)
- C_INIT_VALUE, 32'h00000000, reset value of the register
- OPB_Clk  in  1  sole clock; bus and user logic both run on it
- OPB_Rst_n  in  1  reset, asynchronous assert, active-low
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables, BE[0] = bits [0:7] (MSB byte)
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data, zero except in the ack cycle of a read
- Sl_xferAck  out  1  transfer acknowledge, one-cycle pulse
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_out  out  [31:0]  stored word; user bit 31 = OPB bit 0
- user_data_valid  out  1  one-cycle pulse after every accepted write
- user_write_count  out  [15:0]  number of accepted writes, wraps

## Operation
- FSM states: IDLE, ACK.
- IDLE: at a clock edge with OPB_select=1 and OPB_ABus inside the window -> ACK; capture RNW. Otherwise stay IDLE.
- On IDLE->ACK edge with RNW=0: for each lane i with BE[i]=1, register byte i <= DBus byte i; lanes with BE[i]=0 unchanged. BE=4'b0000 is still acked, register unchanged, valid still pulses, count increments.
- On IDLE->ACK edge with RNW=1: Sl_DBus register loaded with current word (see Configuration).
- ACK: Sl_xferAck=1 for exactly this cycle; unconditional -> IDLE. Request lines are not sampled in ACK, so a still-asserted select cannot double-ack.
- user_write_count increments by 1 mod 2^16 per accepted write; 16'hFFFF -> 16'h0000.
- Address outside window: no ack, no state change, all Sl_* stay 0 (wired-OR bus).

## Timing
- Reset (OPB_Rst_n=0, any time including mid-ACK): state=IDLE, Sl_DBus=0, Sl_xferAck=0, user_data_out=C_INIT_VALUE, user_data_valid=0, user_write_count=0; all immediate, asynchronous. Release synchronised externally.
- Request sampled at edge E; Sl_xferAck, user_data_valid, new user_data_out and count all visible in cycle E+1 (1-cycle latency, all registered outputs).
- Minimum transfer spacing 2 cycles; a new request may be sampled at the edge ending the ACK cycle's successor.
- Sl_DBus returns to 0 the cycle after ACK.

## Configuration
- OPB_REG_READBACK_EN defined: reads return user_data_out on Sl_DBus in the ack cycle.
- Undefined: reads are acked with identical timing but Sl_DBus stays 0; read-data register not instantiated.

## Structure
- Shared package opb_reg_pkg: FSM state enum, OPB byte-lane count constant, function mapping OPB [0:31] order to [31:0].
- Sub-module opb_be_merge: combinational byte-enable merge of old word and bus data; reused by future multi-word registers.

## Test plan
- Reset with C_INIT_VALUE=32'hDEADBEEF -> user_data_out=32'hDEADBEEF, count=0, all Sl_* 0.
- Write 32'h12345678 BE=1111 to C_BASEADDR -> xferAck one cycle later for one cycle, user_data_out=32'h12345678, valid pulse, count=1.
- Then write 32'hAABBCCDD BE=0101 -> user_data_out=32'h12BB56DD.
- Read with macro defined -> Sl_DBus=32'h12BB56DD in ack cycle, 0 otherwise; undefined -> 0 with ack.
- Select with address C_HIGHADDR+4 -> no ack, register and count unchanged; select held high through ACK -> exactly one ack per two cycles.
- 65536 writes -> count wraps to 0; assert OPB_Rst_n low during ACK -> xferAck drops same cycle, outputs at reset values.

Source files
------------

// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB single-word register blocks.
// Holds the bus FSM state type, byte-lane count and OPB bit-order conversion.
package opb_reg_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  localparam int OPB_NUM_LANES = 4;

  // OPB numbers bit 0 as the MSB; user logic wants a conventional [31:0] word.
  function automatic logic [31:0] opb_to_user(input logic [0:31] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[31-i] = w[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_be_merge.sv
// Byte-enable merge of a stored word with new bus data, in user [31:0] order.
// Lane i covers bits [8*i+7:8*i]; lane 3 is the OPB MSB byte.
module opb_be_merge
  import opb_reg_pkg::*;
(
  input  logic [31:0]              old_i,
  input  logic [31:0]              data_i,
  input  logic [OPB_NUM_LANES-1:0] be_i,
  output logic [31:0]              merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < OPB_NUM_LANES; i++) begin
      if (be_i[i]) begin
        merged_o[8*i +: 8] = data_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave holding one PPC-written word for Simulink user logic, with write strobe and count.
// Define OPB_REG_READBACK_EN to return the stored word on Sl_DBus during read acks.
module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_valid,
  output logic [15:0] user_write_count,
  output state_e      dbg_state_o
);

  localparam logic [31:0] WINDOW_SPAN = C_HIGHADDR - C_BASEADDR;

  state_e      state_q, state_d;
  logic [31:0] data_q;
  logic        valid_q;
  logic [15:0] count_q;
  logic [31:0] addr_off;
  logic        in_window;
  logic        hit;
  logic        wr_hit;
  logic [3:0]  be_user;
  logic [31:0] merged;
  logic        unused_ok;

  // Offset compare folds the lower bound in: addresses below base wrap past the span.
  assign addr_off  = opb_to_user(OPB_ABus) - C_BASEADDR;
  assign in_window = (addr_off <= WINDOW_SPAN);
  assign hit       = (state_q == ST_IDLE) && OPB_select && in_window;
  assign wr_hit    = hit && !OPB_RNW;

  // Positional copy puts OPB BE[0] (MSB byte) on lane 3.
  assign be_user = OPB_BE;

  opb_be_merge u_merge (
    .old_i    (data_q),
    .data_i   (opb_to_user(OPB_DBus)),
    .be_i     (be_user),
    .merged_o (merged)
  );

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The ACK state never samples the request, so a held select cannot double-ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Sl_xferAck = (state_q == ST_ACK);
    Sl_errAck  = 1'b0;
    Sl_retry   = 1'b0;
    Sl_toutSup = 1'b0;
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q  <= C_INIT_VALUE;
      valid_q <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      valid_q <= wr_hit;
      if (wr_hit) begin
        data_q  <= merged;
        count_q <= count_q + 16'd1;
      end
    end
  end

`ifdef OPB_REG_READBACK_EN
  logic [31:0] rd_data_q;

  // Loaded only for the ack cycle of a read; zero otherwise so the wired-OR bus stays clean.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rd_data_q <= 32'h0000_0000;
    end else if (hit && OPB_RNW) begin
      rd_data_q <= data_q;
    end else begin
      rd_data_q <= 32'h0000_0000;
    end
  end

  assign Sl_DBus = rd_data_q;
`else
  assign Sl_DBus = '0;
`endif

  assign user_data_out    = data_q;
  assign user_data_valid  = valid_q;
  assign user_write_count = count_q;
  assign dbg_state_o      = state_q;

  assign unused_ok = OPB_seqAddr ^ (C_OPB_AWIDTH == 32) ^ (C_OPB_DWIDTH == 32);

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed bench for opb_register_ppc2simulink with an expected-response queue.
// Follows OPB_REG_READBACK_EN to decide whether reads return data.
module tb_opb_register_ppc2simulink;
  import opb_reg_pkg::*;

  localparam int          W        = 81;
  localparam logic [31:0] INIT_VAL = 32'hDEAD_BEEF;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam logic [31:0] HIGH     = 32'h0000_00FF;
`ifdef OPB_REG_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be_bus;
  logic [0:31] dbus;
  logic        rnw_s;
  logic        sel;
  logic        seq_addr;
  logic [0:31] sl_dbus;
  logic        sl_xferack, sl_errack, sl_retry, sl_toutsup;
  logic [31:0] user_data;
  logic        user_valid;
  logic [15:0] user_count;
  state_e      dbg_state;

  // Entry layout: {read data, user_data_out, write count, valid}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  opb_register_ppc2simulink #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_INIT_VALUE (INIT_VAL)
  ) dut (
    .OPB_Clk          (clk),
    .OPB_Rst_n        (rst_n),
    .OPB_ABus         (abus),
    .OPB_BE           (be_bus),
    .OPB_DBus         (dbus),
    .OPB_RNW          (rnw_s),
    .OPB_select       (sel),
    .OPB_seqAddr      (seq_addr),
    .Sl_DBus          (sl_dbus),
    .Sl_xferAck       (sl_xferack),
    .Sl_errAck        (sl_errack),
    .Sl_retry         (sl_retry),
    .Sl_toutSup       (sl_toutsup),
    .user_data_out    (user_data),
    .user_data_valid  (user_valid),
    .user_write_count (user_count),
    .dbg_state_o      (dbg_state)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic [31:0] data,
                          input logic [15:0] cnt, input logic valid);
    exp_q.push_back({rd, data, cnt, valid});
  endtask

  // Issue one transfer; select is dropped during the ACK cycle.
  task automatic xfer(input logic rnw, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] data);
    @(negedge clk);
    abus = addr; be_bus = be; dbus = data; rnw_s = rnw; sel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sel = 1'b0; be_bus = 4'b0000; dbus = '0;
    @(posedge clk);
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst_n) begin
      check32("tied_zero_outputs", {29'b0, sl_errack, sl_retry, sl_toutsup}, 32'h0);
      if (sl_xferack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack=1 expected no ack (data %h count %h)",
                   user_data, user_count);
        end else begin
          e = exp_q.pop_front();
          check32("ack_sl_dbus", sl_dbus, e[80:49]);
          check32("ack_user_data", user_data, e[48:17]);
          check32("ack_write_count", {16'h0, user_count}, {16'h0, e[16:1]});
          check32("ack_valid", {31'h0, user_valid}, {31'h0, e[0]});
        end
      end else begin
        check32("idle_sl_dbus", sl_dbus, 32'h0);
        check32("idle_valid", {31'h0, user_valid}, 32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; abus = '0; be_bus = '0; dbus = '0; rnw_s = 1'b0; sel = 1'b0; seq_addr = 1'b0;
    repeat (2) @(negedge clk);
    check32("reset_user_data", user_data, INIT_VAL);
    check32("reset_count", {16'h0, user_count}, 32'h0);
    check32("reset_sl", {sl_dbus}, 32'h0);
    check32("reset_ack_valid", {30'h0, sl_xferack, user_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full write, then partial-lane write
    push_exp(32'h0, 32'h1234_5678, 16'd1, 1'b1);
    xfer(1'b0, BASE, 4'b1111, 32'h1234_5678);
    push_exp(32'h0, 32'h12BB_56DD, 16'd2, 1'b1);
    xfer(1'b0, BASE, 4'b0101, 32'hAABB_CCDD);

    // Read back
    push_exp(RB ? 32'h12BB_56DD : 32'h0, 32'h12BB_56DD, 16'd2, 1'b0);
    xfer(1'b1, BASE, 4'b1111, 32'h0);

    // Out of window: no ack, nothing changes
    xfer(1'b0, HIGH + 32'd4, 4'b1111, 32'hFFFF_FFFF);
    @(negedge clk);
    check32("oow_user_data", user_data, 32'h12BB_56DD);
    check32("oow_count", {16'h0, user_count}, 32'd2);

    // No byte enables: acked, word unchanged, still counted
    push_exp(32'h0, 32'h12BB_56DD, 16'd3, 1'b1);
    xfer(1'b0, BASE, 4'b0000, 32'hFFFF_FFFF);

    // Select held for six edges: exactly three acks
    @(negedge clk);
    abus = BASE + 32'h10; be_bus = 4'b1111; dbus = 32'h0F0F_0F0F; rnw_s = 1'b0; sel = 1'b1;
    push_exp(32'h0, 32'h0F0F_0F0F, 16'd4, 1'b1);
    push_exp(32'h0, 32'h0F0F_0F0F, 16'd5, 1'b1);
    push_exp(32'h0, 32'h0F0F_0F0F, 16'd6, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
    check32("held_select_drained", exp_q.size(), 32'd0);

    // Top of window, MSB lane only
    push_exp(32'h0, 32'h110F_0F0F, 16'd7, 1'b1);
    xfer(1'b0, 32'h0000_00FC, 4'b1000, 32'h1122_3344);

    // Count wrap: preload near the top, then six writes
    @(negedge clk);
    force dut.count_q = 16'hFFFC;
    #1;
    release dut.count_q;
    for (int i = 0; i < 6; i++) begin
      push_exp(32'h0, 32'h110F_1000 + i, 16'hFFFD + 16'(i), 1'b1);
      xfer(1'b0, BASE, 4'b0011, 32'h0000_1000 + i);
    end
    push_exp(RB ? 32'h110F_1005 : 32'h0, 32'h110F_1005, 16'd2, 1'b0);
    xfer(1'b1, BASE + 32'h4, 4'b1111, 32'h0);

    // Reset asserted inside the ACK cycle
    @(negedge clk);
    abus = BASE; be_bus = 4'b1111; dbus = 32'hCAFE_F00D; rnw_s = 1'b0; sel = 1'b1;
    @(posedge clk);
    #1;
    check32("pre_reset_ack", {31'h0, sl_xferack}, 32'd1);
    #1;
    rst_n = 1'b0; sel = 1'b0;
    #1;
    check32("midack_reset_ack", {31'h0, sl_xferack}, 32'h0);
    check32("midack_reset_data", user_data, INIT_VAL);
    check32("midack_reset_count", {16'h0, user_count}, 32'h0);
    check32("midack_reset_valid_dbus", {31'h0, user_valid} | sl_dbus, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    push_exp(RB ? INIT_VAL : 32'h0, INIT_VAL, 16'd0, 1'b0);
    xfer(1'b1, BASE, 4'b1111, 32'h0);

    repeat (4) @(negedge clk);
    check32("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
